// File: rtl/snn_layer_serial.sv
// Serial spiking layer: NEURONS leaky integrate-and-fire neurons time-multiplexed
// over one datapath, one neuron evaluated per clock, binary +1/-1 synapses.
module snn_layer_serial #(
    parameter int SYNAPSES = 16,
    parameter int NEURONS  = 16,
    parameter int POT_BITS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        clear,
    input  logic [SYNAPSES-1:0]         inputs,
    input  logic [NEURONS*SYNAPSES-1:0] weights,
    input  logic [2:0]                  shift,
    input  logic [POT_BITS-2:0]         threshold,
    input  logic                        reset_mode,
    output logic                        busy,
    output logic                        done,
    output logic [NEURONS-1:0]          spikes
);
    localparam int NW = $clog2(NEURONS);
    localparam int CW = $clog2(SYNAPSES + 1);
    localparam int PW = POT_BITS + 1;
    localparam logic signed [PW-1:0] P_MAX = {2'b00, {(POT_BITS-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {2'b11, {(POT_BITS-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                             state_q, state_d;
    logic [NW-1:0]                      n_q, n_d;
    logic [SYNAPSES-1:0]                in_q, in_d;
    logic [NEURONS-1:0][POT_BITS-1:0]   u_q, u_d;
    logic [NEURONS-1:0]                 stage_q, stage_d;
    logic [NEURONS-1:0]                 spikes_q, spikes_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic [SYNAPSES-1:0]                w_cur;
    logic [CW-1:0]                      n_pos, n_act;
    logic signed [PW-1:0]               s_sum, u_ext, l_val, p_raw, p_sat, th_ext;
    logic [POT_BITS-1:0]                u_new;
    logic                               fire;

    // Evaluate the neuron selected by n_q: weighted sum, leak, saturate, fire
    always_comb begin
        w_cur = weights[SYNAPSES*int'(n_q) +: SYNAPSES];
        n_pos = '0;
        n_act = '0;
        for (int j = 0; j < SYNAPSES; j++) begin
            n_act = n_act + CW'(in_q[j]);
            n_pos = n_pos + CW'(in_q[j] & w_cur[j]);
        end
        s_sum = $signed(PW'(n_pos) << 1) - $signed(PW'(n_act));
        u_ext = {u_q[n_q][POT_BITS-1], u_q[n_q]};
        if (shift == 3'd0) begin
            l_val = u_ext;
        end else begin
            l_val = u_ext - (u_ext >>> shift);
        end
        p_raw = l_val + s_sum;
        if (p_raw > P_MAX) begin
            p_sat = P_MAX;
        end else if (p_raw < P_MIN) begin
            p_sat = P_MIN;
        end else begin
            p_sat = p_raw;
        end
        th_ext = {2'b00, threshold};
        fire   = (p_sat >= th_ext);
        if (!fire) begin
            u_new = p_sat[POT_BITS-1:0];
        end else if (reset_mode) begin
            u_new = p_sat[POT_BITS-1:0] - {1'b0, threshold};
        end else begin
            u_new = '0;
        end
    end

    // Sequencing: accept start/clear in IDLE, walk neurons in RUN, publish spikes at end
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        in_d     = in_q;
        u_d      = u_q;
        stage_d  = stage_q;
        spikes_d = spikes_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    u_d = '0;
                end else if (start) begin
                    in_d    = inputs;
                    n_d     = '0;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                u_d[n_q]     = u_new;
                stage_d[n_q] = fire;
                n_d          = n_q + NW'(1);
                if (n_q == NW'(NEURONS - 1)) begin
                    n_d      = '0;
                    spikes_d = stage_d;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // State registers; reset aborts any timestep in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            in_q     <= '0;
            u_q      <= '0;
            stage_q  <= '0;
            spikes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            in_q     <= in_d;
            u_q      <= u_d;
            stage_q  <= stage_d;
            spikes_q <= spikes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign spikes = spikes_q;

endmodule

// File: tb/tb_snn_layer_serial.sv
// Bench for snn_layer_serial: directed scenarios plus random timesteps
// checked against an integer LIF reference model.
module tb_snn_layer_serial;
    localparam int N = 4;
    localparam int S = 8;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic [S-1:0]   inputs = '0;
    logic [N*S-1:0] weights = '0;
    logic [2:0]     shift = '0;
    logic [P-2:0]   threshold = '0;
    logic           reset_mode = 1'b0;
    logic           busy;
    logic           done;
    logic [N-1:0]   spikes;

    int checks = 0;
    int passed = 0;
    int um [N];

    localparam logic [N*S-1:0] W_ONES = {(N*S){1'b1}};

    snn_layer_serial #(.SYNAPSES(S), .NEURONS(N), .POT_BITS(P)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .inputs(inputs), .weights(weights), .shift(shift),
        .threshold(threshold), .reset_mode(reset_mode),
        .busy(busy), .done(done), .spikes(spikes)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(int a, int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // One timestep of the whole layer in plain integer arithmetic
    function automatic logic [N-1:0] model_step(logic [S-1:0] in, logic [N*S-1:0] w,
                                                int sh, int th, bit rm);
        logic [N-1:0] sp;
        int hi, lo;
        sp = '0;
        hi = (1 << (P - 1)) - 1;
        lo = -(1 << (P - 1));
        for (int i = 0; i < N; i++) begin
            int s, l, p;
            s = 0;
            for (int j = 0; j < S; j++)
                if (in[j]) s += w[i*S+j] ? 1 : -1;
            l = (sh == 0) ? um[i] : um[i] - floor_div(um[i], 1 << sh);
            p = l + s;
            if (p > hi) p = hi;
            if (p < lo) p = lo;
            if (p >= th) begin
                sp[i] = 1'b1;
                um[i] = rm ? p - th : 0;
            end else begin
                um[i] = p;
            end
        end
        return sp;
    endfunction

    function automatic logic [N*P-1:0] model_u();
        logic [N*P-1:0] r;
        logic [31:0] t;
        for (int i = 0; i < N; i++) begin
            t = um[i];
            r[i*P +: P] = t[P-1:0];
        end
        return r;
    endfunction

    // Drive one start and follow it to done; returns what was observed
    task automatic run_step(input logic [S-1:0] in, input logic [N*S-1:0] w,
                            input logic [2:0] sh, input logic [P-2:0] th,
                            input logic rm, output int lat,
                            output logic [N-1:0] sp, output bit busy_ok);
        inputs = in; weights = w; shift = sh; threshold = th; reset_mode = rm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inputs = S'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        sp = spikes;
        if (busy !== 1'b0) busy_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < N; i++) um[i] = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (spikes !== 4'h0) $display("FAIL reset_spikes got %h want 0", spikes); else passed++;
        for (int i = 0; i < N; i++) um[i] = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fire_zero();
        int lat; logic [N-1:0] sp, e; bit bok;
        e = model_step(8'hFF, W_ONES, 0, 5, 1'b0);
        run_step(8'hFF, W_ONES, 3'd0, 7'd5, 1'b0, lat, sp, bok);
        checks++; if (lat !== N + 1) $display("FAIL fz_latency got %0d want %0d", lat, N + 1); else passed++;
        checks++; if (!bok) $display("FAIL fz_busy got bad pattern want high edges 0-3"); else passed++;
        checks++; if (sp !== 4'hF || sp !== e) $display("FAIL fz_spikes got %h want %h", sp, e); else passed++;
        checks++; if (dut.u_q !== model_u()) $display("FAIL fz_u got %h want %h", dut.u_q, model_u()); else passed++;
    endtask

    task automatic test_subtract();
        int lat; logic [N-1:0] sp, e; bit bok;
        for (int k = 0; k < 2; k++) begin
            e = model_step(8'hFF, W_ONES, 0, 5, 1'b1);
            run_step(8'hFF, W_ONES, 3'd0, 7'd5, 1'b1, lat, sp, bok);
            checks++; if (lat !== N + 1 || !bok) $display("FAIL sub_timing step %0d got lat %0d want %0d", k, lat, N + 1); else passed++;
            checks++; if (sp !== e) $display("FAIL sub_spikes step %0d got %h want %h", k, sp, e); else passed++;
            checks++; if (dut.u_q !== model_u()) $display("FAIL sub_u step %0d got %h want %h", k, dut.u_q, model_u()); else passed++;
        end
        checks++; if (dut.u_q !== {N{8'd6}}) $display("FAIL sub_u_final got %h want 06060606", dut.u_q); else passed++;
    endtask

    task automatic test_leak();
        int lat; logic [N-1:0] sp, e; bit bok;
        int seq [4] = '{3, 2, 1, 1};
        for (int k = 0; k < 4; k++) begin
            e = model_step(8'h00, W_ONES, 1, 5, 1'b1);
            run_step(8'h00, W_ONES, 3'd1, 7'd5, 1'b1, lat, sp, bok);
            checks++; if (sp !== 4'h0 || sp !== e) $display("FAIL leak_spikes step %0d got %h want 0", k, sp); else passed++;
            checks++; if (dut.u_q !== model_u() || um[0] != seq[k])
                $display("FAIL leak_u step %0d got %h want %0d", k, dut.u_q, seq[k]); else passed++;
        end
    endtask

    task automatic test_saturate();
        int lat; logic [N-1:0] sp, e; bit bok;
        do_clear();
        checks++; if (dut.u_q !== '0) $display("FAIL clear_u got %h want 0", dut.u_q); else passed++;
        for (int k = 0; k < 20; k++) begin
            e = model_step(8'hFF, '0, 0, 5, 1'b0);
            run_step(8'hFF, '0, 3'd0, 7'd5, 1'b0, lat, sp, bok);
            checks++; if (sp !== e || dut.u_q !== model_u())
                $display("FAIL sat_step %0d got sp %h u %h want sp %h u %h", k, sp, dut.u_q, e, model_u()); else passed++;
        end
        checks++; if (dut.u_q !== {N{8'h80}}) $display("FAIL sat_floor got %h want 80808080", dut.u_q); else passed++;
    endtask

    task automatic test_ignore();
        logic [N-1:0] e;
        do_clear();
        e = model_step(8'hFF, W_ONES, 0, 5, 1'b1);
        inputs = 8'hFF; weights = W_ONES; shift = 3'd0; threshold = 7'd5; reset_mode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) $display("FAIL ign_done got %b want 1", done); else passed++;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ign_requeue got busy %b done %b want 0 0", busy, done); else passed++;
        checks++; if (dut.u_q !== model_u() || spikes !== e)
            $display("FAIL ign_state got u %h sp %h want u %h sp %h", dut.u_q, spikes, model_u(), e); else passed++;
        @(negedge clk);
        start = 1'b1; clear = 1'b1;
        @(posedge clk); #1 start = 1'b0; clear = 1'b0;
        for (int i = 0; i < N; i++) um[i] = 0;
        checks++; if (busy !== 1'b0) $display("FAIL clrstart_busy got %b want 0", busy); else passed++;
        checks++; if (dut.u_q !== model_u()) $display("FAIL clrstart_u got %h want 0", dut.u_q); else passed++;
        checks++; if (spikes !== e) $display("FAIL clrstart_spikes got %h want %h", spikes, e); else passed++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || spikes !== 4'h0 || dut.u_q !== '0)
            $display("FAIL abort_state got busy %b sp %h u %h want 0 0 0", busy, spikes, dut.u_q); else passed++;
        @(negedge clk) reset = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            end
            checks++; if (seen) $display("FAIL abort_done got activity want none"); else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; logic [N-1:0] sp, e; bit bok;
        logic [S-1:0] in; logic [N*S-1:0] w; logic [2:0] sh; logic [P-2:0] th; logic rm;
        do_clear();
        for (int k = 0; k < 16; k++) begin
            in = S'($urandom);
            w  = $urandom;
            sh = 3'($urandom_range(0, 7));
            th = 7'($urandom_range(0, 10));
            rm = 1'($urandom);
            e = model_step(in, w, int'(sh), int'(th), rm);
            run_step(in, w, sh, th, rm, lat, sp, bok);
            checks++; if (lat !== N + 1 || !bok) $display("FAIL b2b_timing step %0d got lat %0d want %0d", k, lat, N + 1); else passed++;
            checks++; if (sp !== e) $display("FAIL b2b_spikes step %0d got %h want %h", k, sp, e); else passed++;
            checks++; if (dut.u_q !== model_u()) $display("FAIL b2b_u step %0d got %h want %h", k, dut.u_q, model_u()); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fire_zero();
        test_subtract();
        test_leak();
        test_saturate();
        test_ignore();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/snn_layer_serial.md
SNN_LAYER_SERIAL -- requirements
Module: snn_layer_serial

Interface
REQ-001 Parameter SYNAPSES, default 16: number of binary spike inputs per neuron.
REQ-002 Parameter NEURONS, default 16: number of time-multiplexed LIF neurons, minimum 2.
REQ-003 Parameter POT_BITS, default 8: signed two's-complement membrane potential width, minimum $clog2(SYNAPSES)+2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-high.
REQ-006 start  input  1  request one layer timestep; sampled only in IDLE.
REQ-007 clear  input  1  zero all membrane potentials; sampled only in IDLE.
REQ-008 inputs  input  SYNAPSES  input spike vector; latched on accepted start.
REQ-009 weights  input  NEURONS*SYNAPSES  binary weights, neuron i at [SYNAPSES*i +: SYNAPSES]; 1 = +1, 0 = -1; held stable while busy.
REQ-010 shift  input  3  leak shift amount; 0 = no leak.
REQ-011 threshold  input  POT_BITS-1  unsigned firing threshold; held stable while busy.
REQ-012 reset_mode  input  1  0 = reset potential to zero on spike, 1 = subtract threshold.
REQ-013 busy  output  1  high while a timestep is in progress.
REQ-014 done  output  1  one-cycle pulse when a timestep completes.
REQ-015 spikes  output  NEURONS  registered spike vector of the last completed timestep.

Function
REQ-016 States IDLE and RUN; neuron index counter n, $clog2(NEURONS) bits; potential array u[0..NEURONS-1].
REQ-017 IDLE with start=1, clear=0 on edge k: latch inputs, n<=0, enter RUN, busy<=1.
REQ-018 RUN on edge k+1+i (i = 0..NEURONS-1): update neuron i, n<=n+1; exactly one neuron per cycle.
REQ-019 Sum: s = popcount(inputs & w_i) - popcount(inputs & ~w_i), signed, range -SYNAPSES..+SYNAPSES.
REQ-020 Leak: l = u_i - (u_i >>> shift) when shift != 0, else l = u_i; arithmetic shift.
REQ-021 Integrate: p = l + s computed at POT_BITS+1 bits, saturated to [-2^(POT_BITS-1), 2^(POT_BITS-1)-1].
REQ-022 Fire when p >= threshold (signed compare, threshold zero-extended): spike bit i = 1; u_i <= 0 (reset_mode=0) or p - threshold (reset_mode=1); else spike bit i = 0, u_i <= p.
REQ-023 Spike bits collect in a staging register; spikes output updates all bits together on edge k+NEURONS; unchanged otherwise.
REQ-024 Edge k+NEURONS: busy<=0, done<=1, return to IDLE; done clears on the following edge.
REQ-025 Latency start to done = NEURONS+1 edges; a new start is accepted on the cycle done is high; back-to-back timesteps give busy low for exactly one cycle between them.
REQ-026 start and clear in RUN: ignored, not queued.
REQ-027 IDLE with clear=1: all u_i<=0 on next edge; spikes unchanged; clear has priority over a simultaneous start, which is dropped.
REQ-028 Input changes while busy have no effect on the timestep; only latched inputs are used.

Reset
REQ-029 reset=1 asynchronously forces IDLE, n=0, all u_i=0, staging=0, spikes=0, busy=0, done=0.
REQ-030 reset asserted mid-RUN aborts the timestep; spikes stay 0; no done pulse is issued.

Verification (NEURONS=4, SYNAPSES=8, POT_BITS=8)
REQ-031 Reset: assert reset without a clock edge -> busy=0, done=0, spikes=4'h0 immediately.
REQ-032 weights all 1, inputs=8'hFF, threshold=5, shift=0, reset_mode=0, start at edge 0 -> busy high for edges 1-4, done=1 and spikes=4'hF after edge 4, all u=0.
REQ-033 Same with reset_mode=1, two timesteps -> u=3 after first, second gives p=11, spikes=4'hF, u=6.
REQ-034 weights all 0, inputs=8'hFF, 20 timesteps -> u saturates at -128 from step 16 on, spikes=4'h0, no wraparound.
REQ-035 u=6, inputs=8'h00, shift=1 -> u sequence 3, 2, 1, 1 over four timesteps; spikes=4'h0.
REQ-036 start pulsed at edges 2 and 3 of a run -> ignored; clear+start together in IDLE -> u=0, no busy; reset at edge 2 of a run -> busy=0, no done.
